// File: rtl/clk_rst_reset_sequencer.sv
// Per-domain reset sequencer: hold all domain resets, then release
// them in index order with programmable gaps; software re-run handshake.
module clk_rst_reset_sequencer #(
  parameter int FANOUT      = 4,
  parameter int DLY_W       = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sw_rst_req,
  output logic                    sw_rst_ack,
  input  logic [FANOUT*DLY_W-1:0] dly_cfg,
  output logic [FANOUT-1:0]       rst_out_n,
  output logic                    seq_busy,
  output logic                    seq_done
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int IW = (FANOUT > 1) ? $clog2(FANOUT) : 1;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    IDLE    = 2'd2
  } state_t;

  state_t state, state_n;

  logic [HW-1:0]           hold_cnt, hold_n;
  logic [IW-1:0]           idx, idx_n;
  logic [DLY_W-1:0]        dly_cnt, dly_n;
  logic [FANOUT*DLY_W-1:0] dly_lat, lat_n;
  logic [FANOUT-1:0]       rst_n_n;
  logic                    req_q;
  logic                    ack_n, busy_n, done_n;

  logic [DLY_W-1:0] dly_arr [FANOUT];
  logic [DLY_W-1:0] cur_dly;
  logic             hold_done, dly_hit, last_idx;

  always_comb begin
    for (int i = 0; i < FANOUT; i++) begin
      dly_arr[i] = dly_lat[i*DLY_W +: DLY_W];
    end
  end

  assign cur_dly   = dly_arr[idx];
  assign hold_done = (hold_cnt == HW'(HOLD_CYCLES - 1));
  assign dly_hit   = (dly_cnt == cur_dly);
  assign last_idx  = (idx == IW'(FANOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ASSERT;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (sw_rst_req) begin
      state_n = ASSERT;
    end else begin
      case (state)
        ASSERT:  if (hold_done) state_n = RELEASE;
        RELEASE: if (dly_hit && last_idx) state_n = IDLE;
        IDLE:    state_n = IDLE;
        default: state_n = ASSERT;
      endcase
    end
  end

  always_comb begin
    hold_n  = hold_cnt;
    idx_n   = idx;
    dly_n   = dly_cnt;
    lat_n   = dly_lat;
    rst_n_n = rst_out_n;
    ack_n   = sw_rst_req & ~req_q;
    busy_n  = (state_n != IDLE);
    done_n  = (state_n == IDLE);
    if (sw_rst_req) begin
      hold_n  = '0;
      idx_n   = '0;
      dly_n   = '0;
      rst_n_n = '0;
    end else begin
      case (state)
        ASSERT: begin
          rst_n_n = '0;
          if (hold_done) begin
            idx_n = '0;
            dly_n = '0;
            lat_n = dly_cfg;
          end else if (hold_cnt != HW'(HOLD_CYCLES)) begin
            hold_n = hold_cnt + HW'(1);
          end
        end
        RELEASE: begin
          // compare before counting so a gap of 2^DLY_W-1 never wraps
          if (dly_hit) begin
            rst_n_n[idx] = 1'b1;
            dly_n        = '0;
            if (!last_idx) idx_n = idx + IW'(1);
          end else begin
            dly_n = dly_cnt + DLY_W'(1);
          end
        end
        IDLE:    rst_n_n = '1;
        default: rst_n_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt   <= '0;
      idx        <= '0;
      dly_cnt    <= '0;
      dly_lat    <= '0;
      rst_out_n  <= '0;
      req_q      <= 1'b0;
      sw_rst_ack <= 1'b0;
      seq_busy   <= 1'b1;
      seq_done   <= 1'b0;
    end else begin
      hold_cnt   <= hold_n;
      idx        <= idx_n;
      dly_cnt    <= dly_n;
      dly_lat    <= lat_n;
      rst_out_n  <= rst_n_n;
      req_q      <= sw_rst_req;
      sw_rst_ack <= ack_n;
      seq_busy   <= busy_n;
      seq_done   <= done_n;
    end
  end

endmodule

// File: tb/tb_clk_rst_reset_sequencer.sv
// Directed bench for clk_rst_reset_sequencer: release timing,
// software re-run, abort, async reset and delay latching.
module tb_clk_rst_reset_sequencer;

  logic        clk;
  logic        reset;
  logic        sw_rst_req;
  logic        sw_rst_ack;
  logic [31:0] dly_cfg;
  logic [3:0]  rst_out_n;
  logic        seq_busy;
  logic        seq_done;

  int n_chk;
  int n_pass;

  clk_rst_reset_sequencer #(
    .FANOUT(4),
    .DLY_W(8),
    .HOLD_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_rst_req(sw_rst_req),
    .sw_rst_ack(sw_rst_ack),
    .dly_cfg(dly_cfg),
    .rst_out_n(rst_out_n),
    .seq_busy(seq_busy),
    .seq_done(seq_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // k counts edges after the reference edge; bit i high once k >= r[i]
  task automatic expect_seq(input string tag, input int r0, input int r1,
                            input int r2, input int r3, input int last);
    logic [3:0] e;
    for (int k = 1; k <= last; k++) begin
      step();
      e = {k >= r3, k >= r2, k >= r1, k >= r0};
      chk({tag, "_rst"}, rst_out_n, e);
      if (k == 1) chk({tag, "_ack0"}, sw_rst_ack, 0);
      if (k == r3 - 1) chk({tag, "_done0"}, seq_done, 0);
      if (k == last) begin
        chk({tag, "_done1"}, seq_done, 1);
        chk({tag, "_busy0"}, seq_busy, 0);
      end
    end
  endtask

  task automatic pulse_req(input string tag);
    sw_rst_req = 1'b1;
    step();
    chk({tag, "_ack1"}, sw_rst_ack, 1);
    chk({tag, "_rst0"}, rst_out_n, 0);
    chk({tag, "_busy1"}, seq_busy, 1);
    sw_rst_req = 1'b0;
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    reset      = 1'b0;
    sw_rst_req = 1'b0;
    dly_cfg    = {8'd1, 8'd5, 8'd0, 8'd2};
    #1 reset = 1'b1;
    #1;
    chk("rst_out", rst_out_n, 0);
    chk("rst_busy", seq_busy, 1);
    chk("rst_done", seq_done, 0);
    chk("rst_ack", sw_rst_ack, 0);
    reset = 1'b0;

    // power-up sequence
    expect_seq("t1", 19, 20, 26, 28, 30);

    // software re-run from IDLE
    pulse_req("t2");
    expect_seq("t2", 19, 20, 26, 28, 30);

    // abort mid-RELEASE after domains 0 and 1
    pulse_req("t3a");
    for (int k = 1; k <= 20; k++) step();
    chk("t3_part", rst_out_n, 4'b0011);
    pulse_req("t3b");
    expect_seq("t3", 19, 20, 26, 28, 30);

    // async reset between edges mid-RELEASE
    pulse_req("t4a");
    for (int k = 1; k <= 21; k++) step();
    chk("t4_part", rst_out_n, 4'b0011);
    #2 reset = 1'b1;
    #1;
    chk("t4_async", rst_out_n, 0);
    chk("t4_busy", seq_busy, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    expect_seq("t4", 19, 20, 26, 28, 30);

    // zero gaps, with a held request acked only once
    dly_cfg    = 32'h0;
    sw_rst_req = 1'b1;
    step();
    chk("t5_ack1", sw_rst_ack, 1);
    step();
    chk("t5_ackhold", sw_rst_ack, 0);
    chk("t5_rsthold", rst_out_n, 0);
    step();
    sw_rst_req = 1'b0;
    expect_seq("t5a", 17, 18, 19, 20, 22);

    // maximum gap on domain 0
    dly_cfg = {8'd0, 8'd0, 8'd0, 8'hFF};
    pulse_req("t5b");
    expect_seq("t5b", 272, 273, 274, 275, 277);

    // cfg change during RELEASE is ignored
    dly_cfg = {8'd1, 8'd5, 8'd0, 8'd2};
    pulse_req("t6");
    fork
      expect_seq("t6", 19, 20, 26, 28, 30);
      begin
        repeat (18) @(posedge clk);
        #2 dly_cfg = {8'd7, 8'd0, 8'd9, 8'd0};
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
